mult_share_arb: RTL and testbench



---
 rtl/mult_share_arb.sv | 119 +++++++++++
 tb/tb_mult_share_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one iterative 32x32 multiplier between two requesters.
// Optional zero-operand bypass enabled by defining MULT_SHARE_ZERO_BYPASS_EN.
module mult_share_arb #(
  parameter int WDOG_CYCLES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [63:0] rsp0_product,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp1_product,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_busy,
  input  logic [63:0] mult_product,
  output logic        arb_busy,
  output logic        wdog_err
);
  localparam int CW = $clog2(WDOG_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;
  state_t state, state_nxt;

  logic          last_grant, grant, sel, hs, rsp_hs, zero_op, wdog_hit, run_done;
  logic [31:0]   sel_a, sel_b;
  logic [CW-1:0] wdog_cnt;

  // Tie goes to whoever did not win last; otherwise the only valid requester wins.
  always_comb begin
    sel   = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
    sel_a = sel ? req1_a : req0_a;
    sel_b = sel ? req1_b : req0_b;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !sel;
  assign req1_ready = (state == IDLE) && req1_valid && sel;
  assign hs         = req0_ready || req1_ready;
  assign rsp_hs     = grant ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
  assign wdog_hit   = mult_busy && (wdog_cnt == CW'(WDOG_CYCLES - 1));
  assign run_done   = !mult_busy || wdog_hit;
  assign mult_start = (state == START);
  assign arb_busy   = (state != IDLE);

`ifdef MULT_SHARE_ZERO_BYPASS_EN
  assign zero_op = (sel_a == 32'd0) || (sel_b == 32'd0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = zero_op ? RESP : START;
      START:   state_nxt = RUN;
      RUN:     if (run_done) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      mult_a       <= '0;
      mult_b       <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_product <= '0;
      rsp1_product <= '0;
      wdog_err     <= 1'b0;
      wdog_cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          mult_a     <= sel_a;
          mult_b     <= sel_b;
          grant      <= sel;
          last_grant <= sel;
          if (zero_op) begin
            if (sel) begin rsp1_valid <= 1'b1; rsp1_product <= '0; end
            else     begin rsp0_valid <= 1'b1; rsp0_product <= '0; end
          end
        end
        START: wdog_cnt <= '0;
        RUN: begin
          wdog_cnt <= wdog_cnt + CW'(1);
          // An aborted op still answers, with a zero product, so the requester never stalls.
          if (run_done) begin
            if (grant) begin rsp1_valid <= 1'b1; rsp1_product <= wdog_hit ? '0 : mult_product; end
            else       begin rsp0_valid <= 1'b1; rsp0_product <= wdog_hit ? '0 : mult_product; end
            if (wdog_hit) wdog_err <= 1'b1;
          end
        end
        RESP: if (rsp_hs) begin
          if (grant) rsp1_valid <= 1'b0;
          else       rsp0_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a behavioural iterative multiplier model.
module tb_mult_share_arb;
`ifdef MULT_SHARE_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        req0_valid = 0, req0_ready, req1_valid = 0, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        rsp0_valid, rsp0_ready = 0, rsp1_valid, rsp1_ready = 0;
  logic [63:0] rsp0_product, rsp1_product;
  logic        mult_start, mult_busy = 0, arb_busy, wdog_err;
  logic [31:0] mult_a, mult_b;
  logic [63:0] mult_product = 0;

  int vec_cnt = 0, err_cnt = 0;
  int start_cnt = 0, mcnt = 0, lat = 5;
  bit hang = 0;

  mult_share_arb #(.WDOG_CYCLES(128)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_product(rsp0_product),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_product(rsp1_product),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_busy(mult_busy), .mult_product(mult_product),
    .arb_busy(arb_busy), .wdog_err(wdog_err));

  always #5 clk = ~clk;

  // Multiplier: busy from the cycle after start for lat cycles, or forever when hang is set.
  always @(posedge clk) begin
    if (reset) begin
      mult_busy <= 1'b0;
      mcnt      <= 0;
    end else if (mult_start) begin
      mult_busy    <= 1'b1;
      mcnt         <= lat;
      mult_product <= {32'd0, mult_a} * {32'd0, mult_b};
      start_cnt    <= start_cnt + 1;
    end else if (mult_busy && !hang) begin
      if (mcnt <= 1) mult_busy <= 1'b0;
      else           mcnt <= mcnt - 1;
    end
  end

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit s, input bit v, input logic [31:0] a, input logic [31:0] b);
    if (s) begin req1_valid = v; req1_a = a; req1_b = b; end
    else   begin req0_valid = v; req0_a = a; req0_b = b; end
  endtask

  // Waits (bounded) on a negedge until rspX_valid; n returns the cycles waited.
  task automatic wait_rsp(input bit s, output bit got, output int n);
    got = 0; n = 0;
    while (!got && n < 300) begin
      if (s ? rsp1_valid : rsp0_valid) got = 1;
      else begin @(negedge clk); n++; end
    end
  endtask

  task automatic finish_rsp(input bit s);
    if (s) rsp1_ready = 1; else rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit exp_start, input string name);
    bit got; int n, st0;
    @(negedge clk);
    drive_req(s, 1, a, b);
    #1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (s ? req1_ready : req0_ready) got = 1;
      else begin @(negedge clk); #1; end
    end
    check({name, " ready"}, got, 1);
    if (!got) begin drive_req(s, 0, 0, 0); return; end
    st0 = start_cnt;
    @(negedge clk);
    drive_req(s, 0, 0, 0);
    check({name, " start"}, mult_start, exp_start);
    wait_rsp(s, got, n);
    check({name, " rsp_valid"}, got, 1);
    check({name, " product"}, s ? rsp1_product : rsp0_product, exp);
    check({name, " other_valid"}, s ? rsp0_valid : rsp1_valid, 0);
    check({name, " start_count"}, start_cnt - st0, exp_start ? 1 : 0);
    if (!exp_start) check({name, " bypass_latency"}, n, 0);
    finish_rsp(s);
    check({name, " valid_drop"}, s ? rsp1_valid : rsp0_valid, 0);
    check({name, " idle"}, arb_busy, 0);
  endtask

  initial begin
    bit got, bad; int n;
    tbl[0] = '{0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    tbl[1] = '{1, 32'h0000_0007, 32'h0000_0009, 64'h0000_0000_0000_003F};
    tbl[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[3] = '{1, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    tbl[4] = '{0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};
    tbl[5] = '{1, 32'h0000_0000, 32'h0000_1234, 64'h0000_0000_0000_0000};
    tbl[6] = '{0, 32'hDEAD_BEEF, 32'h0000_0001, 64'h0000_0000_DEAD_BEEF};

    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("rst arb_busy", arb_busy, 0);
    check("rst rsp_valids", {rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);
    check("rst mult", {mult_start, mult_a, mult_b}, 0);
    check("rst products", rsp0_product | rsp1_product, 0);
    check("rst wdog", wdog_err, 0);

    // Contention from reset: requester 0 first, requester 1 waits then goes.
    drive_req(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive_req(1, 1, 32'h0001_0000, 32'h0001_0000);
    #1;
    check("tie0 ready", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 0;
    check("tie0 mult_a", mult_a, 32'hFFFF_FFFF);
    bad = 0;
    got = 0; n = 0;
    while (!got && n < 300) begin
      if (req1_ready) bad = 1;
      if (rsp0_valid) got = 1; else begin @(negedge clk); n++; end
    end
    check("tie0 rsp", got, 1);
    check("tie0 req1 held off", bad, 0);
    check("tie0 product", rsp0_product, 64'hFFFF_FFFE_0000_0001);
    finish_rsp(0);
    #1;
    check("tie1 ready", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    wait_rsp(1, got, n);
    check("tie1 rsp", got, 1);
    check("tie1 product", rsp1_product, 64'h0000_0001_0000_0000);
    finish_rsp(1);
    drive_req(0, 1, 32'd1, 32'd1);
    drive_req(1, 1, 32'd1, 32'd1);
    #1;
    check("tie2 ready", {req0_ready, req1_ready}, 2'b10);
    drive_req(0, 0, 0, 0);
    drive_req(1, 0, 0, 0);

    for (int i = 0; i < 7; i++)
      do_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].p,
            !(BYP && (tbl[i].a == 0 || tbl[i].b == 0)), $sformatf("vec%0d", i));

    // Response backpressure with requester 0 pending.
    @(negedge clk);
    drive_req(1, 1, 32'd7, 32'd9);
    #1;
    check("bp ready", req1_ready, 1);
    @(negedge clk);
    drive_req(1, 0, 0, 0);
    drive_req(0, 1, 32'd2, 32'd2);
    wait_rsp(1, got, n);
    check("bp rsp", got, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp1_valid || rsp1_product !== 64'd63 || req0_ready || mult_a !== 32'd7 || mult_b !== 32'd9)
        bad = 1;
    end
    check("bp hold", bad, 0);
    finish_rsp(1);
    #1;
    check("bp after", {rsp1_valid, req0_ready}, 2'b01);
    @(negedge clk);
    drive_req(0, 0, 0, 0);
    wait_rsp(0, got, n);
    check("bp req0 product", rsp0_product, 64'd4);
    finish_rsp(0);

    // Watchdog: multiplier never drops busy.
    hang = 1;
    @(negedge clk);
    drive_req(0, 1, 32'd2, 32'd3);
    @(negedge clk);
    drive_req(0, 0, 0, 0);
    check("wd start", mult_start, 1);
    wait_rsp(0, got, n);
    check("wd start_to_rsp", n, 129);
    check("wd product", rsp0_product, 0);
    check("wd err", wdog_err, 1);
    finish_rsp(0);
    check("wd idle", arb_busy, 0);
    check("wd sticky", wdog_err, 1);
    reset = 1;
    @(negedge clk);
    reset = 0; hang = 0;
    check("wd cleared", wdog_err, 0);

    // Reset while the multiplier is running.
    drive_req(1, 1, 32'd5, 32'd5);
    @(negedge clk);
    drive_req(1, 0, 0, 0);
    @(negedge clk);
    check("mid run busy", {arb_busy, mult_busy}, 2'b11);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("mid rst state", {arb_busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, wdog_err}, 0);
    check("mid rst mult_a", mult_a, 0);
    do_op(0, 32'd6, 32'd7, 64'd42, 1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
